// File: rtl/phase_sequencer.sv
// Tick-driven three-phase sequencer (A -> B -> C -> idle) that restarts the
// shared tick timer on every phase entry and reports phase, ticks left and completion.
module phase_sequencer #(
    parameter int CNT_W = 4,
    parameter int T_A   = 5,
    parameter int T_B   = 2,
    parameter int T_C   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    output logic             timer_clr,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             done
);

    localparam int MAX_T = (1 << CNT_W) - 1;

    if (T_A < 1 || T_A > MAX_T || T_B < 1 || T_B > MAX_T || T_C < 1 || T_C > MAX_T)
    begin : g_bad_duration
        $error("phase_sequencer: every phase duration must lie in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DUR_A = CNT_W'(T_A);
    localparam logic [CNT_W-1:0] DUR_B = CNT_W'(T_B);
    localparam logic [CNT_W-1:0] DUR_C = CNT_W'(T_C);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2,
        PH_C = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] remaining_n;
    logic             timer_clr_n;
    logic             done_n;
    logic             busy_n;
    logic [2:0]       phase_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            timer_clr <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            phase     <= 3'b000;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            timer_clr <= timer_clr_n;
            done      <= done_n;
            busy      <= busy_n;
            phase     <= phase_n;
        end
    end

    // Last tick of a phase replaces the decrement, so remaining never reaches 0 inside a phase.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        timer_clr_n = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                remaining_n = '0;
                if (start && !abort) begin
                    state_n     = PH_A;
                    remaining_n = DUR_A;
                    timer_clr_n = 1'b1;
                end
            end
            default: begin
                if (abort) begin
                    state_n     = IDLE;
                    remaining_n = '0;
                end else if (tick) begin
                    if (remaining > ONE) begin
                        remaining_n = remaining - ONE;
                    end else begin
                        case (state)
                            PH_A: begin
                                state_n     = PH_B;
                                remaining_n = DUR_B;
                                timer_clr_n = 1'b1;
                            end
                            PH_B: begin
                                state_n     = PH_C;
                                remaining_n = DUR_C;
                                timer_clr_n = 1'b1;
                            end
                            default: begin
                                state_n     = IDLE;
                                remaining_n = '0;
                                done_n      = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with it when registered.
    always_comb begin
        busy_n  = (state_n != IDLE);
        phase_n = 3'b000;
        case (state_n)
            PH_A:    phase_n = 3'b001;
            PH_B:    phase_n = 3'b010;
            PH_C:    phase_n = 3'b100;
            default: phase_n = 3'b000;
        endcase
    end

endmodule
